// File: rtl/joystick_pos_reader_if.sv
// Joystick pin and sprite-position bundle between the poller and its neighbours.
// master: the poller drives the SPI pins and position outputs; slave: joystick/sprite side.
// Signals: miso, sclk, ss_n, mosi, analog_x, analog_y, sprite_orientation, sample_valid.
interface joystick_pos_reader_if;
    logic        miso;
    logic        sclk;
    logic        ss_n;
    logic        mosi;
    logic [10:0] analog_x;
    logic [10:0] analog_y;
    logic [1:0]  sprite_orientation;
    logic        sample_valid;

    modport master (
        input  miso,
        output sclk, ss_n, mosi, analog_x, analog_y, sprite_orientation, sample_valid
    );

    modport slave (
        output miso,
        input  sclk, ss_n, mosi, analog_x, analog_y, sprite_orientation, sample_valid
    );
endinterface

// File: rtl/joystick_pos_reader.sv
// Purpose: SPI mode-0 master polling a two-axis joystick every POLL_PERIOD cycles,
//          turning deflection into a clamped sprite position and the button into an orientation count.
// Latency: outputs update at the end of the UPDATE cycle that follows the 5th byte; sample_valid pulses 1 cycle.
// Backpressure: none; the position consumer samples whenever it likes, the outputs are stable between polls.
// Ports: clk, reset (sync, active-high), bus (master modport: miso in; sclk/ss_n/mosi and position outputs).
// Option: define JOY_FILTER_EN to low-pass each axis (f += (raw - f) >>> 2) before the deadzone test.
module joystick_pos_reader #(
    parameter int SCLK_HALF   = 50,
    parameter int SS_SETUP    = 1500,
    parameter int BYTE_GAP    = 1000,
    parameter int POLL_PERIOD = 1000000,
    parameter int X_MAX       = 608,
    parameter int Y_MAX       = 448,
    parameter int DEADZONE    = 64,
    parameter int STEP        = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    joystick_pos_reader_if.master bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;

    // One shared down-the-line counter serves SETUP, the SCLK half periods and GAP.
    localparam int CNT_MAX = (SS_SETUP > BYTE_GAP)
                           ? ((SS_SETUP > SCLK_HALF) ? SS_SETUP : SCLK_HALF)
                           : ((BYTE_GAP > SCLK_HALF) ? BYTE_GAP : SCLK_HALF);
    localparam int CW = $clog2(CNT_MAX + 1);
    // Extra bit so a transaction longer than the poll period cannot wrap the timer.
    localparam int TW = $clog2(POLL_PERIOD) + 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(SCLK_HALF - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(BYTE_GAP - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_PERIOD - 1);

    localparam logic [7:0]         CMD     = 8'h80;
    localparam logic [10:0]        X_HOME  = 11'(X_MAX / 2);
    localparam logic [10:0]        Y_HOME  = 11'(Y_MAX / 2);
    localparam logic [10:0]        X_LIM   = 11'(X_MAX);
    localparam logic [10:0]        Y_LIM   = 11'(Y_MAX);
    localparam logic signed [11:0] DZ_HI   = 12'(512 + DEADZONE);
    localparam logic signed [11:0] DZ_LO   = 12'(512 - DEADZONE);
    localparam logic signed [11:0] STEP_S  = 12'(STEP);

    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [2:0]    byte_idx;
    logic [7:0]    shreg;
    logic [7:0]    cmd_sh;
    logic          sclk_q;
    logic          ss_n_q;
    logic          mosi_q;
    logic          sample_valid_q;

    // Only the frame bits that carry meaning are kept.
    logic [7:0]    b0;
    logic [1:0]    b1;
    logic [7:0]    b2;
    logic [1:0]    b3;
    logic          btn;
    logic          btn_prev;

    logic [10:0]   pos_x;
    logic [10:0]   pos_y;
    logic [1:0]    orient;

    logic [9:0]    raw_x;
    logic [9:0]    raw_y;
    logic [9:0]    test_x;
    logic [9:0]    test_y;
    logic [10:0]   x_next;
    logic [10:0]   y_next;

    assign raw_x = {b1, b0};
    assign raw_y = {b3, b2};

`ifdef JOY_FILTER_EN
    logic [9:0]         fx;
    logic [9:0]         fy;
    logic signed [11:0] fx_diff;
    logic signed [11:0] fy_diff;
    logic signed [11:0] fx_sum;
    logic signed [11:0] fy_sum;

    always_comb begin
        fx_diff = {2'b00, raw_x} - {2'b00, fx};
        fy_diff = {2'b00, raw_y} - {2'b00, fy};
        fx_sum  = {2'b00, fx} + (fx_diff >>> 2);
        fy_sum  = {2'b00, fy} + (fy_diff >>> 2);
    end

    assign test_x = fx_sum[9:0];
    assign test_y = fy_sum[9:0];
`else
    assign test_x = raw_x;
    assign test_y = raw_y;
`endif

    // Velocity-mode step with saturation; inv flips direction (screen y grows downwards).
    function automatic logic [10:0] axis_next(input logic [10:0] pos, input logic [9:0] val,
                                              input logic inv, input logic [10:0] lim);
        logic signed [11:0] p;
        logic signed [11:0] v;
        logic signed [11:0] m;
        logic signed [11:0] r;
        p = {1'b0, pos};
        v = {2'b00, val};
        m = {1'b0, lim};
        r = p;
        if (v > DZ_HI) begin
            r = inv ? (p - STEP_S) : (p + STEP_S);
        end else if (v < DZ_LO) begin
            r = inv ? (p + STEP_S) : (p - STEP_S);
        end
        if (r < 12'sd0) begin
            r = 12'sd0;
        end else if (r > m) begin
            r = m;
        end
        return r[10:0];
    endfunction

    assign x_next = axis_next(pos_x, test_x, 1'b0, X_LIM);
    assign y_next = axis_next(pos_y, test_y, 1'b1, Y_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            timer          <= '0;
            cnt            <= '0;
            bit_idx        <= '0;
            byte_idx       <= '0;
            shreg          <= '0;
            cmd_sh         <= '0;
            sclk_q         <= 1'b0;
            ss_n_q         <= 1'b1;
            mosi_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            b0             <= '0;
            b1             <= '0;
            b2             <= '0;
            b3             <= '0;
            btn            <= 1'b0;
            btn_prev       <= 1'b0;
            pos_x          <= X_HOME;
            pos_y          <= Y_HOME;
            orient         <= '0;
`ifdef JOY_FILTER_EN
            fx             <= 10'd512;
            fy             <= 10'd512;
`endif
        end else begin
            sample_valid_q <= 1'b0;
            timer          <= timer + 1'b1;

            case (state)
                S_IDLE: begin
                    if (timer >= TIMER_LAST) begin
                        timer  <= '0;
                        ss_n_q <= 1'b0;
                        cnt    <= '0;
                        state  <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                        mosi_q   <= CMD[7];
                        cmd_sh   <= {CMD[6:0], 1'b0};
                        state    <= S_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!sclk_q) begin
                            // Rising edge: slave changed miso on the previous falling edge.
                            sclk_q <= 1'b1;
                            shreg  <= {shreg[6:0], bus.miso};
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_idx == 3'd7) begin
                                // shreg already holds all 8 bits from the last rising edge.
                                bit_idx <= '0;
                                mosi_q  <= 1'b0;
                                case (byte_idx)
                                    3'd0:    b0  <= shreg;
                                    3'd1:    b1  <= shreg[1:0];
                                    3'd2:    b2  <= shreg;
                                    3'd3:    b3  <= shreg[1:0];
                                    default: btn <= shreg[0];
                                endcase
                                if (byte_idx == 3'd4) begin
                                    ss_n_q <= 1'b1;
                                    state  <= S_UPDATE;
                                end else begin
                                    byte_idx <= byte_idx + 1'b1;
                                    state    <= S_GAP;
                                end
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                mosi_q  <= cmd_sh[7];
                                cmd_sh  <= {cmd_sh[6:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt    <= '0;
                        mosi_q <= CMD[7];
                        cmd_sh <= {CMD[6:0], 1'b0};
                        state  <= S_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_UPDATE: begin
                    pos_x          <= x_next;
                    pos_y          <= y_next;
                    btn_prev       <= btn;
                    sample_valid_q <= 1'b1;
                    if (btn && !btn_prev) begin
                        orient <= orient + 1'b1;
                    end
`ifdef JOY_FILTER_EN
                    fx <= test_x;
                    fy <= test_y;
`endif
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sclk               = sclk_q;
    assign bus.ss_n               = ss_n_q;
    assign bus.mosi               = mosi_q;
    assign bus.analog_x           = pos_x;
    assign bus.analog_y           = pos_y;
    assign bus.sprite_orientation = orient;
    assign bus.sample_valid       = sample_valid_q;

endmodule

// File: tb/tb_joystick_pos_reader.sv
// Bench for joystick_pos_reader: a joystick slave serves frames built from cur_* values,
// a position model predicts outputs per poll, and a per-cycle compare process checks the DUT.
module tb_joystick_pos_reader;
    localparam int POLL = 400;
    localparam int DZ   = 64;
    localparam int STP  = 4;
    localparam int XMAX = 608;
    localparam int YMAX = 448;
    localparam logic [39:0] MOSI_EXP = {8'h80, 8'h80, 8'h80, 8'h80, 8'h80};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    joystick_pos_reader_if bus();

    joystick_pos_reader #(
        .SCLK_HALF(2), .SS_SETUP(4), .BYTE_GAP(3), .POLL_PERIOD(POLL),
        .X_MAX(XMAX), .Y_MAX(YMAX), .DEADZONE(DZ), .STEP(STP)
    ) dut (
        .clk(clk),
        .reset(rst),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- joystick slave ----------------
    int          cur_rx  = 512;
    int          cur_ry  = 512;
    logic        cur_btn = 1'b0;
    int          sent_rx = 512;
    int          sent_ry = 512;
    int          sent_btn = 0;
    logic [39:0] frame   = '0;
    logic [39:0] mosi_sh = '0;
    int          rises   = 0;
    logic        p_ss    = 1'b1;
    logic        p_sclk  = 1'b0;

    assign bus.miso = frame[39];

    always @(bus.ss_n, bus.sclk) begin
        if (p_ss === 1'b1 && bus.ss_n === 1'b0) begin
            sent_rx  = cur_rx;
            sent_ry  = cur_ry;
            sent_btn = int'(cur_btn);
            // Unused upper bits are set to junk so the decoder must ignore them.
            frame = {8'(cur_rx), 6'b101010, 2'(cur_rx >> 8),
                     8'(cur_ry), 6'b110011, 2'(cur_ry >> 8),
                     7'b1010101, cur_btn};
            rises   = 0;
            mosi_sh = '0;
        end else if (bus.ss_n === 1'b0 && p_sclk === 1'b0 && bus.sclk === 1'b1) begin
            rises++;
            mosi_sh = {mosi_sh[38:0], bus.mosi};
        end else if (bus.ss_n === 1'b0 && p_sclk === 1'b1 && bus.sclk === 1'b0) begin
            frame = frame << 1;
        end
        p_ss   = bus.ss_n;
        p_sclk = bus.sclk;
    end

    // ---------------- position model ----------------
    function automatic int step_axis(input int pos, input int v, input bit inv, input int lim);
        int d;
        int r;
        d = 0;
        if (v > 512 + DZ)      d = STP;
        else if (v < 512 - DZ) d = -STP;
        if (inv) d = -d;
        r = pos + d;
        if (r < 0)   r = 0;
        if (r > lim) r = lim;
        return r;
    endfunction

    int exp_x = XMAX / 2;
    int exp_y = YMAX / 2;
    int exp_o = 0;
    int new_x, new_y, new_o;
    int pbtn  = 0;
`ifdef JOY_FILTER_EN
    int fx = 512;
    int fy = 512;
`endif

    initial begin : compare
        bit pend  = 0;
        bit first = 1;
        int rel   = 0;
        logic prev_ss = 1'b1;
        logic prev_rst = 1'b1;
        int vx, vy;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                exp_x = XMAX / 2; exp_y = YMAX / 2; exp_o = 0; pbtn = 0;
`ifdef JOY_FILTER_EN
                fx = 512; fy = 512;
`endif
                pend = 0; first = 1; rel = 0;
                chk("rst_ss_n", bus.ss_n, 1);
                chk("rst_sclk", bus.sclk, 0);
                chk("rst_mosi", bus.mosi, 0);
                chk("rst_valid", bus.sample_valid, 0);
            end else begin
                rel++;
                if (prev_ss === 1'b1 && bus.ss_n === 1'b0 && first) begin
                    chk("start_delay", rel, POLL);
                    first = 0;
                end
                if (pend) begin
                    exp_x = new_x; exp_y = new_y; exp_o = new_o;
                    chk("valid_pulse", bus.sample_valid, 1);
                    pend = 0;
                end else begin
                    chk("valid_idle", bus.sample_valid, 0);
                end
                if (prev_ss === 1'b0 && bus.ss_n === 1'b1 && !prev_rst) begin
                    chk("sclk_rises", rises, 40);
                    chk("mosi_frame", mosi_sh, MOSI_EXP);
                    vx = sent_rx;
                    vy = sent_ry;
`ifdef JOY_FILTER_EN
                    fx = fx + ((sent_rx - fx) >>> 2);
                    fy = fy + ((sent_ry - fy) >>> 2);
                    vx = fx;
                    vy = fy;
`endif
                    new_x = step_axis(exp_x, vx, 1'b0, XMAX);
                    new_y = step_axis(exp_y, vy, 1'b1, YMAX);
                    new_o = (sent_btn == 1 && pbtn == 0) ? (exp_o + 1) % 4 : exp_o;
                    pbtn  = sent_btn;
                    pend  = 1;
                end
            end
            chk("analog_x", bus.analog_x, exp_x);
            chk("analog_y", bus.analog_y, exp_y);
            chk("orientation", bus.sprite_orientation, exp_o);
            prev_ss  = bus.ss_n;
            prev_rst = rst;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_sv();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.sample_valid !== 1'b1 && n < 2 * POLL);
        if (bus.sample_valid !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_sv: got no sample_valid expected one within %0d cycles", 2 * POLL);
        end
    endtask

    initial begin : stim
        int pat[10]  = '{0, 1, 1, 1, 0, 1, 0, 1, 0, 1};
        int olit[10] = '{0, 1, 1, 1, 1, 2, 2, 3, 3, 0};
        int n;

        // 1: reset state, then one full-right poll
        cur_rx = 1023; cur_ry = 512; cur_btn = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_rst_x", bus.analog_x, 304);
        chk("t1_rst_y", bus.analog_y, 224);
        chk("t1_rst_o", bus.sprite_orientation, 0);
        rst = 1'b0;
        wait_sv();
        chk("t1_x", bus.analog_x, 308);
        chk("t1_y", bus.analog_y, 224);

        // 2: full left / full up until both clamp at 0
        cur_rx = 0; cur_ry = 1023;
        repeat (80) wait_sv();
        chk("t2_x", bus.analog_x, 0);
        chk("t2_y", bus.analog_y, 0);

        // 3: exactly on the deadzone edges holds, one past moves
        cur_rx = 576; cur_ry = 448;
        repeat (2) wait_sv();
        chk("t3_hold_x", bus.analog_x, 0);
        chk("t3_hold_y", bus.analog_y, 0);
        cur_rx = 577;
        repeat (2) wait_sv();
        chk("t3_move_x", bus.analog_x, 8);

        // 4: button edges advance orientation once per press
        cur_rx = 512; cur_ry = 512;
        for (int i = 0; i < 10; i++) begin
            cur_btn = pat[i][0];
            wait_sv();
            chk("t4_orient", bus.sprite_orientation, olit[i]);
        end

        // 5: reset in the middle of byte 2
        cur_rx = 1023; cur_ry = 512; cur_btn = 1'b0;
        n = 0;
        while (!(bus.ss_n === 1'b0 && rises >= 20) && n < 2 * POLL) begin
            @(negedge clk);
            n++;
        end
        chk("t5_in_byte2", (bus.ss_n === 1'b0 && rises >= 20) ? 1 : 0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_ss_n", bus.ss_n, 1);
        chk("t5_sclk", bus.sclk, 0);
        chk("t5_valid", bus.sample_valid, 0);
        chk("t5_x", bus.analog_x, 304);
        chk("t5_o", bus.sprite_orientation, 0);
        rst = 1'b0;
        wait_sv();
        chk("t5_after_x", bus.analog_x, 308);
        chk("t5_after_o", bus.sprite_orientation, 0);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
